// File: rtl/pattern_event_filter.sv
// pattern_event_filter
//
// Registered consumer for the single-bit pattern decode of the 5-input
// inverted-input NOR gate. The decode is synchronised, glitch-filtered by a
// consecutive-sample qualifier and turned into a one-cycle event pulse on
// each qualified rising edge. Events are counted for the KCPSM3 input port
// with an acknowledgeable pending/overflow pair.
//
// Build option: define PATTERN_EVENT_SATURATE_EN to make COUNT saturate at
// all-ones on overflow; when undefined COUNT wraps to 0. OVF is set either way.
//
// Parameters:
//   FILTER_LEN - consecutive identical synchronised samples to change level (1..16)
//   CNT_WIDTH  - event counter width (2..16)
//
// Ports:
//   C       clock, rising edge
//   CLR     asynchronous active-high reset
//   CE      clock enable; when low every register holds and O_PULSE reads 0
//   DIN     asynchronous pattern decode from the NOR gate
//   ACK     processor acknowledge; clears COUNT, PEND and OVF
//   O_LEVEL filtered level
//   O_PULSE one-cycle pulse per qualified rising edge
//   PEND    at least one event since the last ACK
//   OVF     counter overflowed since the last ACK
//   COUNT   qualified rising edges since the last ACK

module pattern_event_filter #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 C,
  input  logic                 CLR,
  input  logic                 CE,
  input  logic                 DIN,
  input  logic                 ACK,
  output logic                 O_LEVEL,
  output logic                 O_PULSE,
  output logic                 PEND,
  output logic                 OVF,
  output logic [CNT_WIDTH-1:0] COUNT
);

  typedef enum logic {StLow, StHigh} state_e;

  localparam logic [4:0] FcLast = 5'(FILTER_LEN - 1);

  state_e               state;
  logic                 s1;
  logic                 s2;
  logic [4:0]           fc;
  logic                 pulse_r;
  logic                 pend_r;
  logic                 ovf_r;
  logic [CNT_WIDTH-1:0] count_r;

  logic qualify;  // s2 holds the value that would move us out of the current state
  logic flip;     // qualifying run complete on this edge
  logic rise;     // flip out of LOW: the event

  assign qualify = (state == StLow) ? s2 : ~s2;
  assign flip    = qualify && (fc == FcLast);
  assign rise    = flip && (state == StLow);

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state   <= StLow;
      s1      <= 1'b0;
      s2      <= 1'b0;
      fc      <= 5'd0;
      pulse_r <= 1'b0;
      pend_r  <= 1'b0;
      ovf_r   <= 1'b0;
      count_r <= '0;
    end else if (CE) begin
      s1      <= DIN;
      s2      <= s1;
      pulse_r <= rise;

      // Any break in the qualifying run restarts the count.
      if (!qualify) begin
        fc <= 5'd0;
      end else if (flip) begin
        fc    <= 5'd0;
        state <= (state == StLow) ? StHigh : StLow;
      end else begin
        fc <= fc + 5'd1;
      end

      // ACK wins over the old count, but an event on the same edge survives.
      if (ACK) begin
        count_r <= {{(CNT_WIDTH-1){1'b0}}, rise};
        pend_r  <= rise;
        ovf_r   <= 1'b0;
      end else if (rise) begin
        pend_r <= 1'b1;
        if (&count_r) begin
          ovf_r <= 1'b1;
`ifdef PATTERN_EVENT_SATURATE_EN
          count_r <= count_r;
`else
          count_r <= '0;
`endif
        end else begin
          count_r <= count_r + 1'b1;
        end
      end
    end
  end

  assign O_LEVEL = (state == StHigh);
  // Registered pulse; gated so a stalled cycle never shows a stale pulse.
  assign O_PULSE = pulse_r & CE;
  assign PEND    = pend_r;
  assign OVF     = ovf_r;
  assign COUNT   = count_r;

endmodule

// File: tb/tb_pattern_event_filter.sv
module tb_pattern_event_filter;

  logic       C = 1'b0;
  logic       CLR, CE, DIN, ACK;
  logic       O_LEVEL, O_PULSE, PEND, OVF;
  logic [7:0] COUNT;
  logic       O_LEVEL2, O_PULSE2, PEND2, OVF2;
  logic [1:0] COUNT2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 C = ~C;

  pattern_event_filter #(.FILTER_LEN(4), .CNT_WIDTH(8)) dut (
    .C(C), .CLR(CLR), .CE(CE), .DIN(DIN), .ACK(ACK),
    .O_LEVEL(O_LEVEL), .O_PULSE(O_PULSE), .PEND(PEND), .OVF(OVF), .COUNT(COUNT)
  );

  // Narrow counter copy for the overflow case; shares all inputs.
  pattern_event_filter #(.FILTER_LEN(4), .CNT_WIDTH(2)) dut2 (
    .C(C), .CLR(CLR), .CE(CE), .DIN(DIN), .ACK(ACK),
    .O_LEVEL(O_LEVEL2), .O_PULSE(O_PULSE2), .PEND(PEND2), .OVF(OVF2), .COUNT(COUNT2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic wait_level(input logic lvl);
    for (int i = 0; i < 30; i++) begin
      if (O_LEVEL == lvl) break;
      tick();
    end
    check("level_settle", {31'd0, O_LEVEL}, {31'd0, lvl});
  endtask

  task automatic gen_event();
    logic seen;
    seen = 1'b0;
    DIN  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (O_PULSE) begin
        seen = 1'b1;
        break;
      end
    end
    check("event_pulse", {31'd0, seen}, 32'd1);
    DIN = 1'b0;
    wait_level(1'b0);
  endtask

  logic [1:0] ovf_count;
  logic       any_pulse;

  initial begin
`ifdef PATTERN_EVENT_SATURATE_EN
    ovf_count = 2'd3;
`else
    ovf_count = 2'd0;
`endif
    CLR = 1'b1; CE = 1'b1; DIN = 1'b0; ACK = 1'b0;

    // Reset values
    #12;
    check("rst_level", {31'd0, O_LEVEL}, 32'd0);
    check("rst_pulse", {31'd0, O_PULSE}, 32'd0);
    check("rst_pend",  {31'd0, PEND},    32'd0);
    check("rst_ovf",   {31'd0, OVF},     32'd0);
    check("rst_count", {24'd0, COUNT},   32'd0);
    @(negedge C);
    CLR = 1'b0;

    // Reset and qualify: pulse after the 6th edge with DIN high
    tick();
    DIN = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check("q_pulse", {31'd0, O_PULSE}, (i == 5) ? 32'd1 : 32'd0);
      check("q_level", {31'd0, O_LEVEL}, (i == 5) ? 32'd1 : 32'd0);
    end
    check("q_count", {24'd0, COUNT}, 32'd1);
    check("q_pend",  {31'd0, PEND},  32'd1);
    check("q_ovf",   {31'd0, OVF},   32'd0);
    tick();
    check("q_pulse_one", {31'd0, O_PULSE}, 32'd0);
    check("q_level_hold", {31'd0, O_LEVEL}, 32'd1);

    // Falling has the same latency and no pulse
    DIN = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check("f_level", {31'd0, O_LEVEL}, (i == 5) ? 32'd0 : 32'd1);
      check("f_pulse", {31'd0, O_PULSE}, 32'd0);
    end
    check("f_count", {24'd0, COUNT}, 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("ack_count", {24'd0, COUNT}, 32'd0);
    check("ack_pend",  {31'd0, PEND},  32'd0);

    // Glitch rejection: 3 high, 1 low, 3 high
    any_pulse = 1'b0;
    DIN = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); any_pulse |= O_PULSE; end
    DIN = 1'b0;
    tick(); any_pulse |= O_PULSE;
    DIN = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); any_pulse |= O_PULSE; end
    DIN = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); any_pulse |= O_PULSE | O_LEVEL; end
    check("g_pulse", {31'd0, any_pulse}, 32'd0);
    check("g_level", {31'd0, O_LEVEL},   32'd0);
    check("g_count", {24'd0, COUNT},     32'd0);

    // Five events; narrow copy overflows on its 4th
    for (int i = 0; i < 5; i++) begin
      gen_event();
      if (i == 2) begin
        check("o3_count", {30'd0, COUNT2}, 32'd3);
        check("o3_ovf",   {31'd0, OVF2},   32'd0);
      end
      if (i == 3) begin
        check("o4_count", {30'd0, COUNT2}, {30'd0, ovf_count});
        check("o4_ovf",   {31'd0, OVF2},   32'd1);
      end
    end
    check("c5_count", {24'd0, COUNT}, 32'd5);

    // ACK collides with the 6th event
    DIN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_pre_pulse", {31'd0, O_PULSE}, 32'd0);
    end
    ACK = 1'b1;
    tick();
    check("c_pulse", {31'd0, O_PULSE}, 32'd1);
    check("c_count", {24'd0, COUNT},   32'd1);
    check("c_pend",  {31'd0, PEND},    32'd1);
    check("c_ovf",   {31'd0, OVF},     32'd0);
    check("c_ovf2",  {31'd0, OVF2},    32'd0);
    tick();
    ACK = 1'b0;
    check("c_ack_count", {24'd0, COUNT}, 32'd0);
    check("c_ack_pend",  {31'd0, PEND},  32'd0);
    DIN = 1'b0;
    wait_level(1'b0);

    // Clock enable stall of 10 cycles mid-qualification
    DIN = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("ce_fc_pre", {27'd0, dut.fc}, 32'd2);
    CE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ce_fc",    {27'd0, dut.fc},   32'd2);
      check("ce_pulse", {31'd0, O_PULSE},  32'd0);
      check("ce_count", {24'd0, COUNT},    32'd0);
    end
    CE = 1'b1;
    tick();
    check("ce_pulse_early", {31'd0, O_PULSE}, 32'd0);
    tick();
    check("ce_pulse_on", {31'd0, O_PULSE}, 32'd1);
    check("ce_count_on", {24'd0, COUNT},   32'd1);
    CE = 1'b0;
    #1;
    check("ce_pulse_gated", {31'd0, O_PULSE}, 32'd0);
    CE = 1'b1;
    tick();
    check("ce_pulse_off", {31'd0, O_PULSE}, 32'd0);
    DIN = 1'b0;
    wait_level(1'b0);

    // Asynchronous reset while fc == 2, then fresh qualification
    DIN = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("r_fc_pre", {27'd0, dut.fc}, 32'd2);
    check("r_count_pre", {24'd0, COUNT}, 32'd1);
    #2;
    CLR = 1'b1;
    #1;
    check("r_count", {24'd0, COUNT},  32'd0);
    check("r_pend",  {31'd0, PEND},   32'd0);
    check("r_level", {31'd0, O_LEVEL}, 32'd0);
    check("r_pulse", {31'd0, O_PULSE}, 32'd0);
    check("r_fc",    {27'd0, dut.fc},  32'd0);
    #1;
    CLR = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check("r_q_pulse", {31'd0, O_PULSE}, (i == 5) ? 32'd1 : 32'd0);
    end
    check("r_q_count", {24'd0, COUNT}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
